// File: rtl/cassette_in.sv
// Cassette input front end: synchronizer, glitch filter, edge-to-edge period
// counter and a small read-only register window on the CPU bus.
module cassette_in #(
  parameter int FILTER_LEN = 4,
  parameter int CNT_W      = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        cass_in,
  input  logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        data_oe
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

  localparam logic [15:0] A_LEVEL  = 16'hC060;
  localparam logic [15:0] A_PER_LO = 16'hC061;
  localparam logic [15:0] A_PER_HI = 16'hC062;
  localparam logic [15:0] A_FLAGS  = 16'hC063;

  logic             sync_a_reg;
  logic             sync_b_reg;
  logic             level_reg;
  logic [FW-1:0]    filt_cnt_reg;
  logic [CNT_W-1:0] run_cnt_reg;
  logic [CNT_W-1:0] period_reg;
  logic [7:0]       hi_shadow_reg;
  logic             edge_flag_reg;
  logic             overrun_reg;
  logic [15:0]      prev_addr_reg;

  logic        edge_pulse;
  logic        new_addr;
  logic        acc_per_lo;
  logic        acc_flags;
  logic [15:0] period16;

  // The edge fires in the same cycle the filter commits the new level.
  assign edge_pulse = (sync_b_reg != level_reg) && (filt_cnt_reg == FILT_LAST);
  assign new_addr   = (addr != prev_addr_reg);
  assign acc_per_lo = new_addr && (addr == A_PER_LO);
  assign acc_flags  = new_addr && (addr == A_FLAGS);

  generate
    if (CNT_W >= 16) begin : g_wide
      assign period16 = period_reg[15:0];
    end else begin : g_narrow
      assign period16 = {{(16 - CNT_W){1'b0}}, period_reg};
    end
  endgenerate

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync_a_reg    <= 1'b0;
      sync_b_reg    <= 1'b0;
      level_reg     <= 1'b0;
      filt_cnt_reg  <= '0;
      run_cnt_reg   <= '0;
      period_reg    <= '0;
      hi_shadow_reg <= 8'h00;
      edge_flag_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      prev_addr_reg <= 16'h0000;
    end else begin
      sync_a_reg <= cass_in;
      sync_b_reg <= sync_a_reg;

      if (sync_b_reg == level_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FILT_LAST) begin
        level_reg    <= sync_b_reg;
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end

      if (edge_pulse) begin
        period_reg  <= run_cnt_reg;
        run_cnt_reg <= CNT_W'(1);
      end else if (run_cnt_reg != '1) begin
        run_cnt_reg <= run_cnt_reg + 1'b1;
      end

      // Old high byte is shadowed even if period_reg updates this same cycle.
      if (acc_per_lo) begin
        hi_shadow_reg <= period16[15:8];
      end

      if (edge_pulse) begin
        edge_flag_reg <= 1'b1;
      end else if (acc_flags) begin
        edge_flag_reg <= 1'b0;
      end

      if (acc_flags) begin
        overrun_reg <= 1'b0;
      end else if (edge_pulse && edge_flag_reg) begin
        overrun_reg <= 1'b1;
      end

      prev_addr_reg <= addr;
    end
  end

  always_comb begin
    data_out = 8'h00;
    data_oe  = 1'b0;
    case (addr)
      A_LEVEL: begin
        data_oe  = 1'b1;
        data_out = {level_reg, 7'b0};
      end
      A_PER_LO: begin
        data_oe  = 1'b1;
        data_out = period16[7:0];
      end
      A_PER_HI: begin
        data_oe  = 1'b1;
        data_out = hi_shadow_reg;
      end
      A_FLAGS: begin
        data_oe  = 1'b1;
        data_out = {edge_flag_reg, overrun_reg, 6'b0};
      end
      default: begin
        data_out = 8'h00;
        data_oe  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cassette_in.sv
// Scenario bench for cassette_in: each read pushes its expected bus value into a
// queue and the value is popped and compared one ns after the address settles.
module tb_cassette_in;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        cass_in = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  data_out;
  logic        data_oe;

  typedef struct {
    logic [7:0] data;
    logic       oe;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  cassette_in #(.FILTER_LEN(4), .CNT_W(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .cass_in  (cass_in),
    .addr     (addr),
    .data_out (data_out),
    .data_oe  (data_oe)
  );

  always #5 CLK = ~CLK;

  task automatic expect_rd(input logic [15:0] a, input logic [7:0] d);
    exp_t t;
    t.data = d;
    t.oe   = (a >= 16'hC060) && (a <= 16'hC063);
    addr   = a;
    sb_q.push_back(t);
    $display("t=%0t read addr=%h expect data=%h oe=%b", $time, a, t.data, t.oe);
  endtask

  task automatic start_read(input logic [15:0] a, input logic [7:0] d);
    @(negedge CLK);
    expect_rd(a, d);
  endtask

  task automatic end_read;
    @(negedge CLK);
    addr = 16'h0000;
  endtask

  task automatic test_reset;
    nRST = 1'b0; cass_in = 1'b0; addr = 16'h0000;
    repeat (3) @(negedge CLK);
    expect_rd(16'h0000, 8'h00);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL rst_idle: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      expect_rd(16'hC060 + 16'(i), 8'h00);
      #1 e = sb_q.pop_front(); n_cmp++;
      if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL rst_reg%0d: data_out=%h data_oe=%b required %h/%b", i, data_out, data_oe, e.data, e.oe); end
    end
    @(negedge CLK);
    nRST = 1'b1; addr = 16'h0000;
  endtask

  task automatic test_filter;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); cass_in = 1'b1;
      repeat (3) @(negedge CLK); cass_in = 1'b0;
      repeat (6) @(negedge CLK);
      start_read(16'hC060, 8'h00);
      #1 e = sb_q.pop_front(); n_cmp++;
      if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL short_pulse%0d: data_out=%h data_oe=%b required %h/%b", i, data_out, data_oe, e.data, e.oe); end
      end_read;
    end
    start_read(16'hC063, 8'h00);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL short_pulse_flags: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    // 6-cycle pulse: level must still be low 5 cycles after the step, high at 6.
    @(negedge CLK); cass_in = 1'b1;
    repeat (4) @(negedge CLK);
    start_read(16'hC060, 8'h00);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL step_lat5: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    start_read(16'hC060, 8'h80);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL step_lat6: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    cass_in = 1'b0;
    end_read;
    repeat (10) @(negedge CLK);
    start_read(16'hC060, 8'h00);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL pulse_fall: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC063, 8'hC0);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL pulse_flags: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC063, 8'h00);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL pulse_flags_clr: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
  endtask

  task automatic test_period;
    @(negedge CLK); cass_in = 1'b1;
    repeat (9) @(negedge CLK);
    start_read(16'hC063, 8'h80);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL period_edge1_flag: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    repeat (1125) @(negedge CLK);
    cass_in = 1'b0;
    repeat (7) @(negedge CLK);
    start_read(16'hC061, 8'h70);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL period_lo: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC062, 8'h04);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL period_hi: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC063, 8'h80);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL period_flag: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC063, 8'h00);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL period_flag_clr: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
  endtask

  task automatic test_overrun;
    @(negedge CLK); cass_in = 1'b1;
    repeat (250) @(negedge CLK); cass_in = 1'b0;
    repeat (250) @(negedge CLK); cass_in = 1'b1;
    repeat (7) @(negedge CLK);
    start_read(16'hC061, 8'hFA);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL ovr_period_lo: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC062, 8'h00);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL ovr_period_hi: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC060, 8'h80);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL ovr_level: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC063, 8'hC0);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL ovr_flags: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC063, 8'h00);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL ovr_clr: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
  endtask

  task automatic test_saturation;
    repeat (70000) @(negedge CLK);
    cass_in = 1'b0;
    repeat (4) @(negedge CLK);
    // C061 access lands on the edge cycle: old low byte out, old high byte shadowed.
    start_read(16'hC061, 8'hFA);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL sat_edge_lo_old: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC062, 8'h00);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL sat_edge_hi_old: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC061, 8'hFF);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL sat_lo: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC062, 8'hFF);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL sat_hi: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC063, 8'h80);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL sat_flag: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
  endtask

  task automatic test_shadow;
    start_read(16'hC061, 8'hFF);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL shd_snap_lo: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    @(negedge CLK); cass_in = 1'b1;
    repeat (8) @(negedge CLK);
    start_read(16'hC062, 8'hFF);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL shd_hold_hi: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC061, 8'h11);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL shd_new_lo: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC062, 8'h00);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL shd_new_hi: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC063, 8'h80);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL shd_flag: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    // Hold C063 for 5 cycles while an edge arrives mid-hold.
    @(negedge CLK); cass_in = 1'b0;
    @(negedge CLK);
    start_read(16'hC063, 8'h00);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL hold_first: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    repeat (4) @(negedge CLK);
    expect_rd(16'hC063, 8'h80);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL hold_after_edge: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC063, 8'h80);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL hold_kept: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC063, 8'h00);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL hold_clr: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
  endtask

  task automatic test_back_to_back;
    @(negedge CLK); cass_in = 1'b1;
    repeat (10) @(negedge CLK);
    @(negedge CLK); cass_in = 1'b0;
    repeat (4) @(negedge CLK);
    // This access coincides with the second edge: set wins, overrun is dropped.
    start_read(16'hC063, 8'h80);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL sim_pre_edge: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC063, 8'h80);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL sim_set_wins: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC063, 8'h00);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL sim_clr: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
  endtask

  task automatic test_reset_mid;
    @(negedge CLK); cass_in = 1'b1;
    repeat (10) @(negedge CLK);
    start_read(16'hC060, 8'h80);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL rstm_before: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    #1 nRST = 1'b0; cass_in = 1'b0;
    expect_rd(16'hC060, 8'h00);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL rstm_async: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    repeat (2) @(negedge CLK);
    nRST = 1'b1; addr = 16'h0000;
    repeat (100) @(negedge CLK);
    cass_in = 1'b1;
    repeat (7) @(negedge CLK);
    start_read(16'hC061, 8'h69);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL rstm_period_lo: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC062, 8'h00);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL rstm_period_hi: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
    start_read(16'hC063, 8'h80);
    #1 e = sb_q.pop_front(); n_cmp++;
    if (data_out !== e.data || data_oe !== e.oe) begin n_err++; $display("FAIL rstm_flag: data_out=%h data_oe=%b required %h/%b", data_out, data_oe, e.data, e.oe); end
    end_read;
  endtask

  initial begin
    test_reset;
    test_filter;
    test_period;
    test_overrun;
    test_saturation;
    test_shadow;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
